// File: rtl/fetch_pkg.sv
// Shared fetch/decode/control definitions: redirect codes, bubble encoding, default widths.
package fetch_pkg;
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 16;
  localparam logic [15:0] NOP_INST_DEF = 16'h0000;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_ALWAYS = 2'b01,
    JMP_ZERO   = 2'b10,
    JMP_RSVD   = 2'b11
  } jmp_e;

  // JMP_RSVD deliberately falls through as "no redirect".
  function automatic logic is_taken(input logic [1:0] jump, input logic zero);
    return (jump == JMP_ALWAYS) || ((jump == JMP_ZERO) && zero);
  endfunction
endpackage

// File: rtl/fetch_pc_next.sv
// Next-address selection for fetch: ROM address to present and next sequential fetch PC.
module pc_next_9 #(
  parameter int AW = 9
) (
  input  logic [AW-1:0] fpc,
  input  logic [AW-1:0] req_pc,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] disp,
  input  logic          taken,
  input  logic          stall,
  output logic [AW-1:0] imem_addr,
  output logic [AW-1:0] fpc_nxt
);
  logic [AW-1:0] target;

  // Modulo-2^AW add: negative displacements wrap naturally.
  assign target = br_pc + disp;

  always_comb begin
    imem_addr = fpc;
    fpc_nxt   = fpc + AW'(1);
    if (taken) begin
      imem_addr = target;
      fpc_nxt   = target + AW'(1);
    end else if (stall) begin
      // Re-present the outstanding address so rdata is still right when stall drops.
      imem_addr = req_pc;
      fpc_nxt   = fpc;
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC sequencing, 1-cycle ROM interface, bubble insertion on reset/redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [DW-1:0] NOP_INST = DW'(NOP_INST_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [1:0]    jump,
  input  logic          zero,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] disp,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] PC,
  output logic          valid
);
  logic [AW-1:0] fpc_q, req_pc_q, pc_q;
  logic          req_valid_q, valid_q;
  logic [DW-1:0] inst_q;
  logic [AW-1:0] fpc_d, addr_d;
  logic          taken;

  assign taken = is_taken(jump, zero);

  pc_next_9 #(.AW(AW)) u_pc_next (
    .fpc       (fpc_q),
    .req_pc    (req_pc_q),
    .br_pc     (br_pc),
    .disp      (disp),
    .taken     (taken),
    .stall     (stall),
    .imem_addr (addr_d),
    .fpc_nxt   (fpc_d)
  );

  assign imem_addr = rst ? RESET_PC : addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      inst_q      <= NOP_INST;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else if (taken) begin
      // Flush: the word returning this cycle is wrong-path; PC holds.
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      req_pc_q    <= addr_d;
      req_valid_q <= 1'b1;
      fpc_q       <= fpc_d;
    end else if (!stall) begin
      inst_q      <= req_valid_q ? imem_rdata : NOP_INST;
      pc_q        <= req_pc_q;
      valid_q     <= req_valid_q;
      req_pc_q    <= fpc_q;
      req_valid_q <= 1'b1;
      fpc_q       <= fpc_d;
    end
  end

  assign inst  = inst_q;
  assign PC    = pc_q;
  assign valid = valid_q;
endmodule
